// File: rtl/i2c_slave_regs_if.sv
// Register-file strobe bus between the I2C slave (master side) and the
// register file it accesses (slave side).
interface i2c_slave_regs_if #(
   parameter int unsigned PTR_W = 8
);
   logic [PTR_W-1:0] reg_addr;
   logic [7:0]       reg_wdata;
   logic             reg_we;
   logic             reg_re;
   logic [7:0]       reg_rdata;

   modport master (
      output reg_addr, reg_wdata, reg_we, reg_re,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr, reg_wdata, reg_we, reg_re,
      output reg_rdata
   );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C slave with burst register access and an auto-incrementing pointer.
// Define I2C_GENERAL_CALL_EN to also accept general-call writes (address byte 0x00).
module i2c_slave_regs #(
   parameter logic [6:0]  SLAVE_ADDR = 7'h01,
   parameter int unsigned PTR_W      = 8,
   parameter int unsigned FILT_LEN   = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               scl_in,
   input  logic               sda_in,
   output logic               sda_oe,
   i2c_slave_regs_if.master   rif,
   output logic               busy,
   output logic               xfer_done,
   output logic [2:0]         i2c_state
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ADDR      = 3'd1,
      ADDR_ACK  = 3'd2,
      RX_BYTE   = 3'd3,
      RX_ACK    = 3'd4,
      TX_BYTE   = 3'd5,
      TX_ACK    = 3'd6,
      WAIT_STOP = 3'd7
   } state_t;

   // Index 0 carries SCL, index 1 carries SDA through the conditioning chain.
   logic [1:0]      sync1_q, sync2_q;
   logic [1:0]      filt_q, filt_d, filt_prev_q;
   logic [1:0][3:0] cnt_q, cnt_d;

   state_t           state_q, state_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       tx_q, tx_d;
   logic             rw_q, rw_d;
   logic             first_q, first_d;
   logic             matched_q, matched_d;
   logic             cap_q, cap_d;
   logic             sda_oe_q, sda_oe_d;
   logic [PTR_W-1:0] reg_addr_q, reg_addr_d;
   logic [7:0]       reg_wdata_q, reg_wdata_d;
   logic             reg_we_q, reg_we_d;
   logic             reg_re_q, reg_re_d;
   logic             xfer_done_q, xfer_done_d;

   logic scl_rise, scl_fall, sda_rise, sda_fall;
   logic start_cond, stop_cond, sda_f, addr_hit;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int unsigned i = 0; i < 2; i++) begin
         if (sync2_q[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == 4'(FILT_LEN - 1)) begin
            filt_d[i] = sync2_q[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
         end
      end
   end

   assign scl_rise   =  filt_q[0] & ~filt_prev_q[0];
   assign scl_fall   = ~filt_q[0] &  filt_prev_q[0];
   assign sda_rise   =  filt_q[1] & ~filt_prev_q[1];
   assign sda_fall   = ~filt_q[1] &  filt_prev_q[1];
   assign sda_f      =  filt_q[1];
   assign start_cond = sda_fall & filt_q[0];
   assign stop_cond  = sda_rise & filt_q[0];

`ifdef I2C_GENERAL_CALL_EN
   assign addr_hit = (shift_q[7:1] == SLAVE_ADDR) || (shift_q == 8'h00);
`else
   assign addr_hit = (shift_q[7:1] == SLAVE_ADDR);
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tx_d        = tx_q;
      rw_d        = rw_q;
      first_d     = first_q;
      matched_d   = matched_q;
      sda_oe_d    = sda_oe_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;
      xfer_done_d = 1'b0;
      cap_d       = reg_re_q;

      // Post-write pointer bump lands one cycle after the write strobe.
      if (reg_we_q) reg_addr_d = reg_addr_q + PTR_W'(1);

      if (stop_cond) begin
         state_d     = IDLE;
         sda_oe_d    = 1'b0;
         xfer_done_d = matched_q;
         matched_d   = 1'b0;
         cap_d       = 1'b0;
      end else if (start_cond) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
         matched_d = 1'b0;
         cap_d     = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = '0;
                  if (addr_hit) begin
                     state_d   = ADDR_ACK;
                     sda_oe_d  = 1'b1;
                     rw_d      = shift_q[0];
                     matched_d = 1'b1;
                  end else begin
                     state_d = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = '0;
                  if (!rw_q) begin
                     state_d  = RX_BYTE;
                     sda_oe_d = 1'b0;
                     first_d  = 1'b1;
                  end else begin
                     state_d  = TX_BYTE;
                     reg_re_d = 1'b1;
                  end
               end
            end
            RX_BYTE: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d   = RX_ACK;
                  sda_oe_d  = 1'b1;
                  bit_cnt_d = '0;
                  if (first_q) begin
                     reg_addr_d = PTR_W'(shift_q);
                     first_d    = 1'b0;
                  end else begin
                     reg_wdata_d = shift_q;
                     reg_we_d    = 1'b1;
                  end
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  state_d  = RX_BYTE;
                  sda_oe_d = 1'b0;
               end
            end
            TX_BYTE: begin
               // Read data arrives two cycles after the fall that issued reg_re.
               if (cap_q) begin
                  tx_d     = rif.reg_rdata;
                  sda_oe_d = ~rif.reg_rdata[7];
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd7) begin
                     state_d   = TX_ACK;
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                  end else begin
                     sda_oe_d  = ~tx_q[6];
                     tx_d      = {tx_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  if (sda_f) state_d    = WAIT_STOP;
                  else       reg_addr_d = reg_addr_q + PTR_W'(1);
               end else if (scl_fall) begin
                  state_d   = TX_BYTE;
                  reg_re_d  = 1'b1;
                  bit_cnt_d = '0;
               end
            end
            WAIT_STOP: sda_oe_d = 1'b0;
            default:   state_d  = IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         filt_q      <= '1;
         filt_prev_q <= '1;
         cnt_q       <= '0;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tx_q        <= '0;
         rw_q        <= 1'b0;
         first_q     <= 1'b0;
         matched_q   <= 1'b0;
         cap_q       <= 1'b0;
         sda_oe_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
         xfer_done_q <= 1'b0;
      end else begin
         sync1_q     <= {sda_in, scl_in};
         sync2_q     <= sync1_q;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         rw_q        <= rw_d;
         first_q     <= first_d;
         matched_q   <= matched_d;
         cap_q       <= cap_d;
         sda_oe_q    <= sda_oe_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
         xfer_done_q <= xfer_done_d;
      end
   end

   assign sda_oe        = sda_oe_q;
   assign rif.reg_addr  = reg_addr_q;
   assign rif.reg_wdata = reg_wdata_q;
   assign rif.reg_we    = reg_we_q;
   assign rif.reg_re    = reg_re_q;
   assign busy          = (state_q != IDLE);
   assign xfer_done     = xfer_done_q;
   assign i2c_state     = state_q;

endmodule
